fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset; bits [1:0] are forced to 0.
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned read address, held stable while imem_req=1.
REQ-006 SHALL have port imem_ack  input  1  single-cycle pulse; imem_rdata is valid in that cycle.
REQ-007 SHALL have port imem_rdata  input  32  instruction word.
REQ-008 SHALL have port instr  output  32  held instruction; instr[31:26] drives the control decoder opcode.
REQ-009 SHALL have port instr_valid  output  1  instr is valid for decode.
REQ-010 SHALL have port instr_ready  input  1  decode accepts instr this cycle.
REQ-011 SHALL have port branch  input  1  decoder branch output for the held instr.
REQ-012 SHALL have port jump  input  1  decoder jump output for the held instr.
REQ-013 SHALL have port zero  input  1  ALU zero flag for the held instr, valid in the accept cycle.
REQ-014 SHALL have port pc  output  32  address of the held instr.
REQ-015 SHALL have port proto_err  output  1  sticky flag for an imem_ack received outside FETCH.

Function
REQ-016 SHALL implement the states RESET, FETCH and HOLD.
REQ-017 SHALL move from RESET to FETCH in the first cycle with rst_n=1.
REQ-018 SHALL assert imem_req=1 with imem_addr=fetch_pc in FETCH, and only in FETCH.
REQ-019 SHALL, in FETCH when imem_ack=1, capture imem_rdata into instr, capture fetch_pc into pc, and enter HOLD on the next cycle.
REQ-020 SHALL drive instr_valid=1 in HOLD, and only in HOLD.
REQ-021 SHALL keep instr and pc stable in HOLD while instr_ready=0.
REQ-022 SHALL, in HOLD when instr_ready=1, compute the next fetch_pc and enter FETCH on the next cycle.
REQ-023 SHALL compute the next fetch_pc with priority: jump gives {pc4[31:28], instr[25:0], 2'b00}; else branch&zero gives pc4 + (sext(instr[15:0])<<2); else pc4, where pc4 = pc+4.
REQ-024 SHALL ignore branch, jump and zero outside the HOLD accept cycle.
REQ-025 SHALL perform all PC arithmetic modulo 2^32, so pc 32'hFFFF_FFFC gives pc4 32'h0000_0000.
REQ-026 SHALL give the minimum loop of one instruction per 2 cycles plus memory latency: ack, then HOLD accept, then FETCH.
REQ-027 SHALL ignore imem_ack in HOLD or RESET, leave instr unchanged, and set proto_err, which is cleared only by reset.
REQ-028 SHALL keep instr_valid=0 in a cycle where imem_ack and the HOLD transition coincide; instr_valid rises the following cycle.

Reset
REQ-029 SHALL, with rst_n=0 at a clock edge, set state=RESET, fetch_pc=RESET_PC, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0 and proto_err=0.
REQ-030 SHALL abandon any outstanding request when reset occurs mid-FETCH or mid-HOLD; the memory is reset on the same rst_n.

Configuration
REQ-031 SHALL compile counter logic only when macro FETCH_PERF_EN is defined.
REQ-032 SHALL, with FETCH_PERF_EN defined, add outputs fetch_count (32) and redirect_count (32).
REQ-033 SHALL increment fetch_count once per HOLD accept, and increment redirect_count on an accept with jump or branch&zero.
REQ-034 SHALL reset both counters to 0 and let them wrap modulo 2^32.
REQ-035 SHALL, without FETCH_PERF_EN, have neither port and no counter logic.

Structure
REQ-036 SHALL place the state enum, opcode field positions [31:26], immediate field [15:0] and jump field [25:0] in a shared package cpu_pkg.
REQ-037 SHALL place next-PC computation in one combinational sub-module next_pc_calc with inputs pc, instr, branch, jump and zero, and output next_pc.

Verification
REQ-038 SHALL cover reset release with RESET_PC=32'h100 -> imem_req=1 and imem_addr=32'h100 on the first cycle after rst_n rises.
REQ-039 SHALL cover sequential flow: ack with 32'h8C01_0004, then accept with branch=jump=0 -> next imem_addr=32'h104.
REQ-040 SHALL cover a taken branch: pc=32'h200, instr imm=16'hFFFE, branch=1, zero=1 -> imem_addr=32'h1FC; with zero=0 -> imem_addr=32'h204.
REQ-041 SHALL cover a jump: pc=32'h3000_0010, instr[25:0]=26'h000_0040, jump=1 -> imem_addr=32'h3000_0100.
REQ-042 SHALL cover backpressure and errors: instr_ready=0 for 5 cycles in HOLD -> instr and pc stable with imem_req=0; an imem_ack in HOLD -> proto_err=1 and instr unchanged.
REQ-043 SHALL cover reset mid-FETCH: rst_n=0 for 1 cycle while imem_req=1 -> outputs return to reset values and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and instruction field positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // Opcode field, consumed by the control decoder
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    // Branch immediate field (signed word offset)
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Jump target field (word index within the current 256 MB region)
    localparam int JTGT_MSB   = 25;
    localparam int JTGT_LSB   = 0;

    // Sign-extend a 16-bit word offset and convert it to a byte offset
    function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
        logic signed [31:0] ofs;
        ofs = {{14{imm[15]}}, imm, 2'b00};
        return ofs;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next fetch address for the held instruction: jump, taken branch or pc+4.
// All arithmetic wraps modulo 2^32.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0]        pc4;
    logic signed [31:0] br_ofs;
    logic [31:0]        br_tgt;
    logic [31:0]        jmp_tgt;
    logic               unused_opcode;

    assign pc4     = pc + 32'd4;
    assign br_ofs  = branch_offset(instr[IMM_MSB:IMM_LSB]);
    assign br_tgt  = pc4 + $unsigned(br_ofs);
    assign jmp_tgt = {pc4[31:28], instr[JTGT_MSB:JTGT_LSB], 2'b00};

    // The opcode bits only matter to the decoder, not to address generation
    assign unused_opcode = ^instr[OPCODE_MSB:OPCODE_LSB];

    // Jump outranks a taken branch; otherwise fall through sequentially
    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = jmp_tgt;
        end else if (branch && zero) begin
            next_pc = br_tgt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: RESET -> FETCH (request until ack) -> HOLD (present
// instr until decode accepts) -> FETCH at the next PC.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc,
    output logic        proto_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
`endif
);

    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  next_pc;
    logic         capture;
    logic         accept;

    // Data is taken only in FETCH; decode handshake only completes in HOLD
    assign capture   = (state == ST_FETCH) && imem_ack;
    assign accept    = (state == ST_HOLD) && instr_ready;
    assign imem_addr = fetch_pc;

    next_pc_calc u_next_pc (
        .pc      (pc),
        .instr   (instr),
        .branch  (branch),
        .jump    (jump),
        .zero    (zero),
        .next_pc (next_pc)
    );

    // State register; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs; instr_valid stays low in the ack cycle
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            ST_RESET: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    // Held instruction, its address, and the address of the next request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC_W;
            pc       <= RESET_PC_W;
            instr    <= 32'h0;
        end else begin
            if (capture) begin
                instr <= imem_rdata;
                pc    <= fetch_pc;
            end
            if (accept) begin
                fetch_pc <= next_pc;
            end
        end
    end

    // Sticky flag for an ack arriving when no request is outstanding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (imem_ack && (state != ST_FETCH)) begin
            proto_err <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    logic redirect;

    assign redirect = jump || (branch && zero);

    // Free-running wrap-around counters of accepted and redirecting instructions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count    <= 32'h0;
            redirect_count <= 32'h0;
        end else if (accept) begin
            fetch_count <= fetch_count + 32'd1;
            if (redirect) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Three instances run in lockstep on shared
// handshakes: the main one (RESET_PC=0x100), one placed where a jump keeps
// nonzero upper PC bits, and one with an unaligned top-of-memory RESET_PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] rdata_j;
    logic [31:0] rdata_w;
    logic        instr_ready;
    logic        branch;
    logic        jump;
    logic        jump_j;
    logic        zero;

    logic        imem_req,  req_j,  req_w;
    logic [31:0] imem_addr, addr_j, addr_w;
    logic [31:0] instr,     instr_j, instr_w;
    logic        instr_valid, valid_j, valid_w;
    logic [31:0] pc,        pc_j,   pc_w;
    logic        proto_err, perr_j, perr_w;
`ifdef FETCH_PERF_EN
    logic [31:0] fcnt, rcnt, fcnt_j, rcnt_j, fcnt_w, rcnt_w;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch(branch), .jump(jump), .zero(zero),
        .pc(pc), .proto_err(proto_err)
`ifdef FETCH_PERF_EN
        , .fetch_count(fcnt), .redirect_count(rcnt)
`endif
    );

    fetch_unit #(.RESET_PC(32'h3000_0010)) dut_j (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_j), .imem_addr(addr_j),
        .imem_ack(imem_ack), .imem_rdata(rdata_j),
        .instr(instr_j), .instr_valid(valid_j), .instr_ready(instr_ready),
        .branch(branch), .jump(jump_j), .zero(zero),
        .pc(pc_j), .proto_err(perr_j)
`ifdef FETCH_PERF_EN
        , .fetch_count(fcnt_j), .redirect_count(rcnt_j)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(imem_ack), .imem_rdata(rdata_w),
        .instr(instr_w), .instr_valid(valid_w), .instr_ready(instr_ready),
        .branch(branch), .jump(1'b0), .zero(zero),
        .pc(pc_w), .proto_err(perr_w)
`ifdef FETCH_PERF_EN
        , .fetch_count(fcnt_w), .redirect_count(rcnt_w)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        rdata_j = 32'h0; rdata_w = 32'h0; instr_ready = 1'b0;
        branch = 1'b0; jump = 1'b0; jump_j = 1'b0; zero = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_req",   {31'h0, imem_req},    32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_pc",    pc,                   32'h0000_0100);
        chk("rst_addr",  imem_addr,            32'h0000_0100);
        chk("rst_instr", instr,                32'h0);
        chk("rst_perr",  {31'h0, proto_err},   32'h0);
        chk("rst_addr_w_aligned", addr_w,      32'hFFFF_FFFC);
        chk("rst_pc_j",  pc_j,                 32'h3000_0010);

        // Reset release: first cycle out of reset issues the request
        rst_n = 1'b1;
        tick();
        chk("rel_req",  {31'h0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr,         32'h0000_0100);

        // Sequential flow; instr_valid low in the ack cycle
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
        rdata_j = 32'h0000_0040; rdata_w = 32'h0000_0000;
        #1;
        chk("ack_cycle_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        imem_ack = 1'b0;
        chk("hold_valid", {31'h0, instr_valid}, 32'h1);
        chk("hold_instr", instr,                32'h8C01_0004);
        chk("hold_pc",    pc,                   32'h0000_0100);
        chk("hold_req",   {31'h0, imem_req},    32'h0);
        instr_ready = 1'b1; jump_j = 1'b1;
        tick();
        instr_ready = 1'b0; jump_j = 1'b0;
        chk("seq_addr",  imem_addr,            32'h0000_0104);
        chk("seq_req",   {31'h0, imem_req},    32'h1);
        chk("seq_valid", {31'h0, instr_valid}, 32'h0);
        chk("jump_addr_j",  addr_j,            32'h3000_0100);
        chk("wrap_addr_w",  addr_w,            32'h0000_0000);

        // Jump from 0x104 to 0x200 in the main instance
        imem_ack = 1'b1; imem_rdata = 32'h0800_0080;
        tick();
        imem_ack = 1'b0;
        chk("j_pc", pc, 32'h0000_0104);
        instr_ready = 1'b1; jump = 1'b1;
        tick();
        instr_ready = 1'b0; jump = 1'b0;
        chk("j_addr", imem_addr, 32'h0000_0200);

        // Branch instruction at 0x200 with imm = -2, held under backpressure
        imem_ack = 1'b1; imem_rdata = 32'h1000_FFFE;
        tick();
        imem_ack = 1'b0;
        chk("br_pc", pc, 32'h0000_0200);
        branch = 1'b1; jump = 1'b1; zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_instr", instr,                32'h1000_FFFE);
            chk("bp_pc",    pc,                   32'h0000_0200);
            chk("bp_req",   {31'h0, imem_req},    32'h0);
            chk("bp_valid", {31'h0, instr_valid}, 32'h1);
        end
        chk("bp_addr", imem_addr, 32'h0000_0200);
        branch = 1'b0; jump = 1'b0; zero = 1'b0;

        // Spurious ack in HOLD
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("perr_set",   {31'h0, proto_err}, 32'h1);
        chk("perr_instr", instr,              32'h1000_FFFE);
        chk("perr_valid", {31'h0, instr_valid}, 32'h1);

        // Taken branch: 0x204 - 8
        instr_ready = 1'b1; branch = 1'b1; zero = 1'b1;
        tick();
        instr_ready = 1'b0; branch = 1'b0; zero = 1'b0;
        chk("taken_addr", imem_addr, 32'h0000_01FC);

        // Sequential back to 0x200, then not-taken branch
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        tick();
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("seq2_addr", imem_addr, 32'h0000_0200);
        imem_ack = 1'b1; imem_rdata = 32'h1000_FFFE;
        tick();
        imem_ack = 1'b0;
        instr_ready = 1'b1; branch = 1'b1; zero = 1'b0;
        tick();
        instr_ready = 1'b0; branch = 1'b0;
        chk("ntaken_addr", imem_addr,          32'h0000_0204);
        chk("perr_sticky", {31'h0, proto_err}, 32'h1);

`ifdef FETCH_PERF_EN
        chk("fetch_count",    fcnt, 32'd5);
        chk("redirect_count", rcnt, 32'd2);
`endif

        // Reset while a request is outstanding
        chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_req",   {31'h0, imem_req},    32'h0);
        chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("mid_rst_pc",    pc,                   32'h0000_0100);
        chk("mid_rst_instr", instr,                32'h0);
        chk("mid_rst_perr",  {31'h0, proto_err},   32'h0);
        chk("mid_rst_addr",  imem_addr,            32'h0000_0100);
`ifdef FETCH_PERF_EN
        chk("mid_rst_fcnt", fcnt, 32'd0);
`endif
        tick();
        chk("restart_req",  {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr,         32'h0000_0100);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
